// File: rtl/x_delay_line_pkg.sv
// Shared constants and types for the delay line and its readout controller.
package x_delay_line_pkg;

    // Number of delay line cells, and so serial bits per measurement.
    localparam int unsigned p_dl_length = 128;

    // Result width: must hold the all-ones count p_dl_length without wrapping.
    localparam int unsigned p_cnt_w = $clog2(p_dl_length + 1);

    // Readout controller states.
    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/x_delay_line_ctrl.sv
// Readout controller for x_delay_line: strobes a capture, shifts the
// thermometer code out serially, accumulates the ones count and a bubble
// flag, and offers the result on a valid/ready handshake.
module x_delay_line_ctrl
    import x_delay_line_pkg::*;
#(
    parameter int unsigned p_dl_length = x_delay_line_pkg::p_dl_length,
    parameter int unsigned p_cnt_w     = $clog2(p_dl_length + 1)
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_dl_en,
    output logic               o_shift_en,
    input  logic               i_shift,
    output logic [p_cnt_w-1:0] o_count,
    output logic               o_bubble,
    output logic               o_valid,
    input  logic               i_ready
);

    // Bit counter spans 0..p_dl_length-1.
    localparam int unsigned lp_bit_w = (p_dl_length > 1) ? $clog2(p_dl_length) : 1;
    localparam logic [lp_bit_w-1:0] lp_last_bit = lp_bit_w'(p_dl_length - 1);
    localparam logic [1:0] lp_trans_sat = 2'd2;

    state_t                r_state;
    logic [lp_bit_w-1:0]   r_bit_cnt;
    logic [p_cnt_w-1:0]    r_count;
    logic [1:0]            r_trans;
    logic                  r_prev;
    logic                  r_busy;
    logic                  r_dl_en;
    logic                  r_shift_en;
    logic                  r_valid;

    logic                  w_first_bit;
    logic                  w_edge_seen;

    // Transition detection only applies from the second sample onward.
    always_comb begin
        w_first_bit = (r_bit_cnt == '0);
        w_edge_seen = !w_first_bit && (i_shift != r_prev);
    end

    // Measurement FSM with its counters and registered strobe/handshake outputs.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_count    <= '0;
            r_trans    <= '0;
            r_prev     <= 1'b0;
            r_busy     <= 1'b0;
            r_dl_en    <= 1'b0;
            r_shift_en <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state   <= CAPTURE;
                        r_busy    <= 1'b1;
                        r_dl_en   <= 1'b1;
                        r_count   <= '0;
                        r_trans   <= '0;
                        r_bit_cnt <= '0;
                        r_prev    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    // Cells latch at the end of this cycle; shifting starts next.
                    r_state    <= SHIFT;
                    r_dl_en    <= 1'b0;
                    r_shift_en <= 1'b1;
                end
                SHIFT: begin
                    r_count <= r_count + p_cnt_w'(i_shift);
                    r_prev  <= i_shift;
                    if (w_edge_seen && (r_trans != lp_trans_sat)) begin
                        r_trans <= r_trans + 2'd1;
                    end
                    // Stop after exactly p_dl_length samples; shifted-in zeros are never seen.
                    if (r_bit_cnt == lp_last_bit) begin
                        r_state    <= DONE;
                        r_shift_en <= 1'b0;
                        r_valid    <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + lp_bit_w'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_dl_en    <= 1'b0;
                    r_shift_en <= 1'b0;
                    r_valid    <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers; no input reaches an output combinationally.
    always_comb begin
        o_busy     = r_busy;
        o_dl_en    = r_dl_en;
        o_shift_en = r_shift_en;
        o_valid    = r_valid;
        o_count    = r_count;
        o_bubble   = (r_trans >= lp_trans_sat);
    end

endmodule

// File: tb/tb_x_delay_line_ctrl.sv
// Scoreboard bench for x_delay_line_ctrl with a behavioural delay line model.
module tb_x_delay_line_ctrl;

    localparam int N = 128;
    localparam int W = 8;

    typedef struct {
        int     cnt;
        bit     bub;
        longint start_e;
    } exp_t;

    logic         i_clk   = 1'b0;
    logic         i_nrst  = 1'b0;
    logic         i_start = 1'b0;
    logic         i_ready = 1'b0;
    logic         o_busy;
    logic         o_dl_en;
    logic         o_shift_en;
    logic         w_shift;
    logic [W-1:0] o_count;
    logic         o_bubble;
    logic         o_valid;

    logic [N-1:0] tb_taps = '0;
    logic [N-1:0] chain   = '0;
    longint       e       = 0;

    exp_t         sb[$];
    int           starts   = 0;
    bit           tb_done  = 1'b0;

    int           checks   = 0;
    int           errors   = 0;
    int           rd_idx   = 0;
    int           dl_seen  = 0;
    int           shifts   = 0;
    bit           prev_valid = 1'b0;
    bit           prev_hs    = 1'b0;
    bit           stable     = 1'b1;
    bit           mon_done   = 1'b0;
    logic [W:0]   held       = '0;

    x_delay_line_ctrl dut (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_dl_en    (o_dl_en),
        .o_shift_en (o_shift_en),
        .i_shift    (w_shift),
        .o_count    (o_count),
        .o_bubble   (o_bubble),
        .o_valid    (o_valid),
        .i_ready    (i_ready)
    );

    initial forever #5 i_clk = ~i_clk;

    always @(posedge i_clk) e <= e + 1;

    // Delay line: capture on dl_en, shift toward the top on shift_en, zeros in.
    always @(posedge i_clk) begin
        if (o_dl_en) chain <= tb_taps;
        else if (o_shift_en) chain <= {chain[N-2:0], 1'b0};
    end
    assign w_shift = chain[N-1];

    // Reference: popcount, and bubble when the code has two or more 0/1 edges.
    function automatic void model(input logic [N-1:0] t, output int cnt, output bit bub);
        int tr;
        cnt = 0;
        tr  = 0;
        for (int i = 0; i < N; i++) cnt += int'(t[i]);
        for (int i = 0; i < N - 1; i++) if (t[i] != t[i+1]) tr++;
        bub = (tr >= 2);
    endfunction

    function automatic logic [N-1:0] thermo(input int n);
        logic [N-1:0] t;
        t = '0;
        for (int i = 0; i < n; i++) t[i] = 1'b1;
        return t;
    endfunction

    function automatic logic [N-1:0] rand_pat();
        logic [N-1:0] t;
        int j;
        t = thermo($urandom_range(0, N));
        case ($urandom_range(0, 3))
            0: begin
                j = $urandom_range(0, N - 1);
                t[j] = ~t[j];
            end
            1: begin
                j = $urandom_range(0, N - 1);
                t[j] = ~t[j];
                j = $urandom_range(0, N - 1);
                t[j] = ~t[j];
            end
            2: t = {$urandom, $urandom, $urandom, $urandom};
            default: ;
        endcase
        return t;
    endfunction

    // Monitor: protocol checks and scoreboard comparison on each handshake.
    initial forever @(negedge i_clk) begin
        if (!i_nrst) begin
            checks++;
            if ({o_busy, o_dl_en, o_shift_en, o_valid, o_bubble, o_count} != '0) begin
                errors++;
                $display("FAIL reset_outputs got busy=%b dl=%b sh=%b v=%b bub=%b cnt=%0d want all 0",
                         o_busy, o_dl_en, o_shift_en, o_valid, o_bubble, o_count);
            end
            rd_idx     = sb.size();
            dl_seen    = starts;
            shifts     = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            stable     = 1'b1;
        end else begin
            if (prev_hs) begin
                checks++;
                if (o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_after_ready busy=%b want 0", o_busy);
                end
            end
            if (o_dl_en && o_shift_en) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap dl_en=1 shift_en=1 want exclusive");
            end
            if (o_dl_en) begin
                checks++;
                if (dl_seen >= starts) begin
                    errors++;
                    $display("FAIL extra_dl_en pulses=%0d accepted_starts=%0d", dl_seen + 1, starts);
                end else begin
                    dl_seen++;
                end
                shifts = 0;
            end
            if (o_shift_en) shifts++;
            if (prev_valid && !o_valid && !prev_hs) begin
                checks++;
                errors++;
                $display("FAIL valid_dropped valid=0 want 1 until handshake");
            end
            if (o_valid && !prev_valid) begin
                checks++;
                if (rd_idx >= sb.size()) begin
                    errors++;
                    $display("FAIL unexpected_valid valid=1 with no outstanding request");
                end else if (e - sb[rd_idx].start_e != 130) begin
                    errors++;
                    $display("FAIL latency got %0d cycles want 130", e - sb[rd_idx].start_e);
                end
                held   = {o_count, o_bubble};
                stable = 1'b1;
            end
            if (o_valid && prev_valid && ({o_count, o_bubble} != held)) stable = 1'b0;
            if (o_valid && i_ready) begin
                if (rd_idx >= sb.size()) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake_no_expect count=%0d want no result", o_count);
                end else begin
                    checks += 4;
                    if (int'(o_count) != sb[rd_idx].cnt) begin
                        errors++;
                        $display("FAIL count got %0d want %0d", o_count, sb[rd_idx].cnt);
                    end
                    if (o_bubble != sb[rd_idx].bub) begin
                        errors++;
                        $display("FAIL bubble got %0b want %0b", o_bubble, sb[rd_idx].bub);
                    end
                    if (shifts != N) begin
                        errors++;
                        $display("FAIL shift_cycles got %0d want %0d", shifts, N);
                    end
                    if (!stable) begin
                        errors++;
                        $display("FAIL result_stable got changed want held during valid");
                    end
                    rd_idx++;
                end
            end
            prev_hs    = o_valid && i_ready;
            prev_valid = o_valid;
            if (tb_done && !mon_done) begin
                checks++;
                if (rd_idx != sb.size()) begin
                    errors++;
                    $display("FAIL drained got %0d results want %0d", rd_idx, sb.size());
                end
                mon_done = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy) begin
            step();
            n++;
            if (n > 1000) begin
                $display("FAIL wait_idle busy stuck after %0d cycles want 0", n);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_valid) begin
            step();
            n++;
            if (n > 400) begin
                $display("FAIL wait_valid valid=0 after %0d cycles want 1", n);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic issue(input logic [N-1:0] t);
        exp_t x;
        int   c;
        bit   b;
        tb_taps = t;
        model(t, c, b);
        x.cnt     = c;
        x.bub     = b;
        x.start_e = e;
        sb.push_back(x);
        starts++;
        i_start = 1'b1;
    endtask

    // One measurement; delay = ready-low cycles after valid, pulse = poke start meanwhile.
    task automatic run_meas(input logic [N-1:0] t, input int delay, input bit pulse);
        wait_idle();
        issue(t);
        if (delay == 0) i_ready = 1'b1;
        step();
        i_start = 1'b0;
        wait_valid();
        for (int d = 0; d < delay; d++) begin
            i_ready = 1'b0;
            i_start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] bub_pat;
        int n;

        repeat (3) step();
        i_nrst = 1'b1;
        step();

        // Directed patterns.
        run_meas(thermo(37), 0, 1'b0);
        run_meas('0, 0, 1'b0);
        run_meas(~thermo(0), 0, 1'b0);
        bub_pat = thermo(20);
        bub_pat[21] = 1'b1;
        run_meas(bub_pat, 2, 1'b0);

        // Randomized patterns and ready delays.
        for (int i = 0; i < 12; i++) begin
            run_meas(rand_pat(), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        // Back-pressure with start pokes, then an immediate restart.
        run_meas(thermo(37), 50, 1'b1);
        run_meas(bub_pat, 0, 1'b0);

        // Reset in the middle of shifting, then a clean remeasure.
        wait_idle();
        issue(thermo(37));
        step();
        i_start = 1'b0;
        n = 0;
        while (!o_shift_en) begin
            step();
            n++;
            if (n > 10) begin
                $display("FAIL wait_shift shift_en=0 want 1");
                $fatal(1, "timeout");
            end
        end
        repeat (59) step();
        i_nrst = 1'b0;
        step();
        i_nrst = 1'b1;
        step();
        run_meas(thermo(37), 0, 1'b0);

        repeat (4) step();
        tb_done = 1'b1;
        n = 0;
        while (!mon_done && n < 10) begin
            step();
            n++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/x_delay_line_ctrl.md
# x_delay_line_ctrl

Controller and decoder directly downstream of `x_delay_line`. On request it issues a one-cycle capture strobe to the delay line and then clocks the captured 128-tap thermometer code out serially. It accumulates the code into a tap count and a bubble flag, and presents the result on a valid/ready handshake to the measurement logic above.

## Interface
Parameters:
- `p_dl_length`, 128: number of delay line cells and serial bits per measurement.
- `p_cnt_w`, $clog2(p_dl_length+1) = 8: result width.

Ports:
- `i_clk`, in, 1: single clock, shared with `x_delay_line`.
- `i_nrst`, in, 1: asynchronous, active-low reset.
- `i_start`, in, 1: request one measurement; sampled only in IDLE.
- `o_busy`, out, 1: high in any state other than IDLE.
- `o_dl_en`, out, 1: capture strobe, drives delay line `i_dl_en`.
- `o_shift_en`, out, 1: serial shift enable, drives delay line `i_shift_en`.
- `i_shift`, in, 1: serial data from delay line `o_shift`.
- `o_count`, out, `p_cnt_w`: number of ones in the captured code (0..128).
- `o_bubble`, out, 1: captured code had more than one 0/1 transition.
- `o_valid`, out, 1: result valid.
- `i_ready`, in, 1: consumer accepts the result.

## Operation
- FSM states are IDLE, CAPTURE, SHIFT and DONE. All outputs are decoded from registered state and registers, with no combinational path from input to output.
- IDLE: `i_start`=1 moves to CAPTURE and clears the count, the bubble flag and the transition counter.
- CAPTURE: lasts exactly one cycle with `o_dl_en`=1. Cells latch their taps at the end of this cycle, then the FSM moves to SHIFT.
- SHIFT: lasts exactly `p_dl_length` cycles with `o_shift_en`=1, tracked by a bit counter from 0 to `p_dl_length`-1.
  - Each cycle `i_shift` is sampled. Sample k is tap `p_dl_length`-1-k.
  - `count += i_shift`.
  - For k>0, a transition is counted when `i_shift` differs from sample k-1. The transition counter saturates at 2.
- The move from SHIFT to DONE happens after the sample with k=`p_dl_length`-1.
- DONE:
  - `o_valid`=1.
  - `o_count` and `o_bubble` are held stable, with `o_bubble` = (transitions ≥ 2).
  - Leaves for IDLE on the first edge with `i_ready`=1.
- `i_start` in any non-IDLE state is ignored, not queued.
- The count register is `p_cnt_w` wide, so all ones gives 128 with no overflow.
- The zeros that the chain shifts in are never sampled. Exactly `p_dl_length` bits are consumed per measurement.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `o_busy`, `o_dl_en`, `o_shift_en`, `o_valid` and `o_bubble` are 0.
  - `o_count` is 0.
  - A measurement in flight is discarded. The next `i_start` fully recaptures, so no stale chain contents are used.

## Timing
- `i_start` seen high at edge N:
  - CAPTURE during cycle N+1.
  - SHIFT during cycles N+2 to N+129.
  - `o_valid`=1 from cycle N+130.
- Minimum start-to-valid latency is 130 cycles, which is `p_dl_length`+2.
- `i_ready` high in the first DONE cycle gives IDLE in the next cycle. A new `i_start` can be accepted there, so the minimum period is 131 cycles.
- `o_dl_en` and `o_shift_en` are never high in the same cycle. Exactly one `o_dl_en` pulse occurs per accepted start.
- `o_valid` does not drop without `i_ready`. `i_ready` outside DONE has no effect.

## Structure
- Shared package `x_delay_line_pkg` holds:
  - the `p_dl_length` constant, shared by `x_delay_line` and this block;
  - the result width constant;
  - the state enum `state_t`, with values IDLE, CAPTURE, SHIFT and DONE.
- There is no sub-module. The FSM, the bit counter, the ones accumulator and the saturating transition counter are all coded inline.
- The top-level wiring instantiates `x_delay_line` and `x_delay_line_ctrl` side by side.

## Test plan
- Clean thermometer: 37 taps are high (taps 0..36) and the rest low. Start, hold `i_ready`=1. Expect `o_count`=37, `o_bubble`=0, `o_valid` at start+130, and exactly 128 `o_shift_en` cycles.
- Extremes: all zeros gives count 0 with bubble 0. All ones gives count 128 with bubble 0, which checks 8-bit width and no wrap.
- Bubble: taps 0..19 high, tap 20 low, tap 21 high, rest low. Expect count 21 and bubble 1.
- Back-pressure: hold `i_ready`=0 for 50 cycles after valid while pulsing `i_start`. Expect `o_count` stable, no new `o_dl_en`, and completion one cycle after `i_ready` rises. Starting again in the following IDLE cycle gives a second correct result.
- Reset mid-SHIFT: assert `i_nrst`=0 during shift cycle 60. Expect all outputs 0 immediately. A new start then gives a correct count of 37 for the clean pattern.
- Protocol assertions: `o_dl_en` and `o_shift_en` are mutually exclusive, there is one `o_dl_en` per accepted start, and `o_valid` stays stable until the handshake.
